// File: rtl/picoramsoc_pkg.sv
// Shared definitions for the PicoRV32 SoC iomem bus fabric.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the arbiter state encoding, the peripheral region constant and the
// default read data returned when a peripheral transaction is aborted.
package picoramsoc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      ABORT = 2'd2
   } arb_state_t;

   // Peripheral window: address bits [31:24] of iomem peripherals.
   localparam logic [7:0]  IOMEM_BASE = 8'h03;

   // Read data handed back to a requester whose transaction was aborted.
   localparam logic [31:0] ERR_RDATA_DFLT = 32'hFFFF_FFFF;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority picker: first set request after last, wrapping at N.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to act on the result.
//
// Ports:
//   req  [N-1:0]  request vector
//   last [W-1:0]  index granted most recently (search starts at last+1)
//   any           at least one request is set
//   idx  [W-1:0]  chosen index, 0 when nothing is requested
// Wrap is modulo N (not 2^W), so non-power-of-two N is legal.
module rr_pick #(
   parameter int N = 4,
   parameter int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] last,
   output logic         any,
   output logic [W-1:0] idx
);

   always_comb begin
      logic [W-1:0] cand;
      int           c;
      any  = 1'b0;
      idx  = '0;
      cand = '0;
      c    = 0;
      // Walk last+1 .. last+N; the last candidate is last itself, so a lone
      // requester that was just served can still be picked again.
      for (int k = 1; k <= N; k++) begin
         c    = (int'(last) + k) % N;
         cand = W'(c);
         if (!any && req[cand]) begin
            any = 1'b1;
            idx = cand;
         end
      end
   end

endmodule

// File: rtl/iomem_arbiter.sv
// Round-robin arbiter sharing the PicoRV32 iomem bus between NREQ requesters.
// Latency: grant registered (iomem_valid one cycle after request seen in IDLE);
// Backpressure: requesters hold req_valid until their req_ready pulse, which is
//               combinational from iomem_ready; one IDLE cycle between grants.
//
// Ports:
//   CLKOUT, resetn (synchronous, active-low)
//   req_valid/req_ready/req_wstrb/req_addr/req_wdata/req_rdata : requester side,
//      per-requester fields packed at [W*i +: W]; req_rdata shared, valid with req_ready
//   iomem_valid/ready/wstrb/addr/wdata/rdata : downstream peripheral bus
//   grant_id  : current/last granted requester
//   busy      : a downstream transaction is in flight
//   timeout_err/err_clr : sticky abort flag and its clear
//
// Optional feature: define IOMEM_ARB_TIMEOUT_EN to abort transactions that
// see no iomem_ready within TIMEOUT_CYCLES; without it BUSY waits forever.
module iomem_arbiter
   import picoramsoc_pkg::*;
#(
   parameter int          NREQ           = 4,
   parameter int          TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DFLT
) (
   input  logic                      CLKOUT,
   input  logic                      resetn,
   input  logic [NREQ-1:0]           req_valid,
   output logic [NREQ-1:0]           req_ready,
   input  logic [4*NREQ-1:0]         req_wstrb,
   input  logic [32*NREQ-1:0]        req_addr,
   input  logic [32*NREQ-1:0]        req_wdata,
   output logic [31:0]               req_rdata,
   output logic                      iomem_valid,
   input  logic                      iomem_ready,
   output logic [3:0]                iomem_wstrb,
   output logic [31:0]               iomem_addr,
   output logic [31:0]               iomem_wdata,
   input  logic [31:0]               iomem_rdata,
   output logic [$clog2(NREQ)-1:0]   grant_id,
   output logic                      busy,
   output logic                      timeout_err,
   input  logic                      err_clr
);

   localparam int GW = $clog2(NREQ);

   arb_state_t      state, state_nxt;
   logic [GW-1:0]   last_grant;
   logic            pick_any;
   logic [GW-1:0]   pick_idx;
   logic            tmo_hit;
   logic            done;

   logic [3:0]      wstrb_arr [NREQ];
   logic [31:0]     addr_arr  [NREQ];
   logic [31:0]     wdata_arr [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign wstrb_arr[i] = req_wstrb[4*i +: 4];
      assign addr_arr[i]  = req_addr[32*i +: 32];
      assign wdata_arr[i] = req_wdata[32*i +: 32];
   end

   rr_pick #(.N(NREQ), .W(GW)) u_pick (
      .req  (req_valid),
      .last (last_grant),
      .any  (pick_any),
      .idx  (pick_idx)
   );

   // Downstream payload follows the registered grant; it is only meaningful
   // while iomem_valid is high.
   assign iomem_wstrb = wstrb_arr[grant_id];
   assign iomem_addr  = addr_arr[grant_id];
   assign iomem_wdata = wdata_arr[grant_id];

   always_comb begin
      state_nxt   = state;
      iomem_valid = 1'b0;
      busy        = 1'b0;
      req_ready   = '0;
      req_rdata   = '0;
      done        = 1'b0;
      case (state)
         IDLE: begin
            if (pick_any) state_nxt = BUSY;
         end
         BUSY: begin
            iomem_valid = 1'b1;
            busy        = 1'b1;
            // Ready has priority over an expiring timeout in the same cycle.
            if (iomem_ready) begin
               req_ready[grant_id] = 1'b1;
               req_rdata           = iomem_rdata;
               done                = 1'b1;
               state_nxt           = IDLE;
            end else if (tmo_hit) begin
               state_nxt = ABORT;
            end
         end
         ABORT: begin
            req_ready[grant_id] = 1'b1;
            req_rdata           = ERR_RDATA;
            done                = 1'b1;
            state_nxt           = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLKOUT) begin
      if (!resetn) begin
         state      <= IDLE;
         grant_id   <= '0;
         last_grant <= GW'(NREQ - 1);
      end else begin
         state <= state_nxt;
         if (state == IDLE && pick_any) grant_id <= pick_idx;
         if (done) last_grant <= grant_id;
      end
   end

`ifdef IOMEM_ARB_TIMEOUT_EN
   logic [15:0] tmo_cnt;

   // Counter value k means k+1 BUSY cycles have elapsed in this cycle, so a
   // hit at TIMEOUT_CYCLES-1 aborts after exactly TIMEOUT_CYCLES BUSY cycles.
   assign tmo_hit = (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge CLKOUT) begin
      if (!resetn) begin
         tmo_cnt     <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (state != BUSY)       tmo_cnt <= '0;
         else if (!iomem_ready)   tmo_cnt <= tmo_cnt + 16'd1;
         // Set wins over a coincident clear.
         if (state == ABORT)      timeout_err <= 1'b1;
         else if (err_clr)        timeout_err <= 1'b0;
      end
   end
`else
   assign tmo_hit     = 1'b0;
   assign timeout_err = 1'b0;

   logic unused_cfg;
   assign unused_cfg = ^{err_clr, ERR_RDATA, 16'(TIMEOUT_CYCLES), IOMEM_BASE};
`endif

endmodule

// File: tb/tb_iomem_arbiter.sv
// Directed self-checking bench for iomem_arbiter (NREQ=4, TIMEOUT_CYCLES=8).
// Latency: checks registered grant timing and combinational completion.
// Backpressure: peripheral ready is driven by hand per scenario.
module tb_iomem_arbiter;

   localparam int NREQ = 4;

   logic               CLKOUT = 1'b0;
   logic               resetn = 1'b0;
   logic [NREQ-1:0]    req_valid = '0;
   logic [NREQ-1:0]    req_ready;
   logic [4*NREQ-1:0]  req_wstrb = '0;
   logic [32*NREQ-1:0] req_addr = '0;
   logic [32*NREQ-1:0] req_wdata = '0;
   logic [31:0]        req_rdata;
   logic               iomem_valid;
   logic               iomem_ready = 1'b0;
   logic [3:0]         iomem_wstrb;
   logic [31:0]        iomem_addr;
   logic [31:0]        iomem_wdata;
   logic [31:0]        iomem_rdata = '0;
   logic [1:0]         grant_id;
   logic               busy;
   logic               timeout_err;
   logic               err_clr = 1'b0;

   int total = 0;
   int bad   = 0;

   iomem_arbiter #(.NREQ(NREQ), .TIMEOUT_CYCLES(8), .ERR_RDATA(32'hFFFF_FFFF)) dut (
      .CLKOUT      (CLKOUT),
      .resetn      (resetn),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_wstrb   (req_wstrb),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_rdata   (req_rdata),
      .iomem_valid (iomem_valid),
      .iomem_ready (iomem_ready),
      .iomem_wstrb (iomem_wstrb),
      .iomem_addr  (iomem_addr),
      .iomem_wdata (iomem_wdata),
      .iomem_rdata (iomem_rdata),
      .grant_id    (grant_id),
      .busy        (busy),
      .timeout_err (timeout_err),
      .err_clr     (err_clr)
   );

   always #5 CLKOUT = ~CLKOUT;

   // Advance one clock; inputs are changed 1 ns after the edge and outputs
   // are sampled 1 ns later, well away from the next rising edge.
   task automatic step();
      @(posedge CLKOUT);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic do_reset();
      resetn      = 1'b0;
      req_valid   = '0;
      iomem_ready = 1'b0;
      err_clr     = 1'b0;
      step();
      step();
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      iomem_ready = 1'b1;
      iomem_rdata = 32'hDEAD_BEEF;
      settle();
      total++;
      if (iomem_valid !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL reset_valid_busy: got valid=%b busy=%b want 0 0", iomem_valid, busy);
      end
      total++;
      if (req_ready !== 4'b0000 || req_rdata !== 32'h0) begin
         bad++; $display("FAIL reset_ready_ignored: got ready=%b rdata=%h want 0000 0", req_ready, req_rdata);
      end
      total++;
      if (grant_id !== 2'd0 || timeout_err !== 1'b0) begin
         bad++; $display("FAIL reset_grant_err: got grant=%0d err=%b want 0 0", grant_id, timeout_err);
      end
      iomem_ready = 1'b0;
   endtask

   task automatic test_single_read();
      req_addr[31:0] = 32'h0300_0000;
      req_wstrb[3:0] = 4'b0000;
      req_valid      = 4'b0001;
      step();
      total++;
      if (iomem_valid !== 1'b1 || iomem_addr !== 32'h0300_0000 || grant_id !== 2'd0 || iomem_wstrb !== 4'b0000) begin
         bad++; $display("FAIL read_issue: got valid=%b addr=%h grant=%0d wstrb=%b want 1 03000000 0 0000",
                         iomem_valid, iomem_addr, grant_id, iomem_wstrb);
      end
      total++;
      if (req_ready !== 4'b0000) begin
         bad++; $display("FAIL read_no_early_ready: got %b want 0000", req_ready);
      end
      iomem_ready = 1'b1;
      iomem_rdata = 32'h0000_00A5;
      settle();
      total++;
      if (req_ready !== 4'b0001 || req_rdata !== 32'h0000_00A5) begin
         bad++; $display("FAIL read_complete: got ready=%b rdata=%h want 0001 000000a5", req_ready, req_rdata);
      end
      step();
      iomem_ready = 1'b0;
      req_valid   = '0;
      settle();
      total++;
      if (iomem_valid !== 1'b0 || req_ready !== 4'b0000) begin
         bad++; $display("FAIL read_idle_after: got valid=%b ready=%b want 0 0000", iomem_valid, req_ready);
      end
   endtask

   task automatic test_fairness();
      int cnt [NREQ];
      int exp;
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
         cnt[i] = 0;
         req_addr[32*i +: 32] = 32'h0300_0010 + 32'(i * 4);
         req_wstrb[4*i +: 4]  = 4'b0000;
      end
      req_valid = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         exp = k % NREQ;
         step();
         total++;
         if (iomem_valid !== 1'b1 || grant_id !== 2'(exp) || iomem_addr !== 32'h0300_0010 + 32'(exp * 4)) begin
            bad++; $display("FAIL fair_grant[%0d]: got valid=%b grant=%0d addr=%h want 1 %0d", k,
                            iomem_valid, grant_id, iomem_addr, exp);
         end
         step();
         iomem_ready = 1'b1;
         iomem_rdata = 32'(k);
         settle();
         for (int i = 0; i < NREQ; i++) if (req_ready[i]) cnt[i]++;
         total++;
         if (req_ready !== 4'(1 << exp)) begin
            bad++; $display("FAIL fair_ready[%0d]: got %b want %b", k, req_ready, 4'(1 << exp));
         end
         step();
         iomem_ready = 1'b0;
         settle();
         total++;
         if (iomem_valid !== 1'b0) begin
            bad++; $display("FAIL fair_idle_gap[%0d]: got valid=%b want 0", k, iomem_valid);
         end
      end
      req_valid = '0;
      for (int i = 0; i < NREQ; i++) begin
         total++;
         if (cnt[i] !== 2) begin
            bad++; $display("FAIL fair_count[%0d]: got %0d want 2", i, cnt[i]);
         end
      end
   endtask

   task automatic test_write_routing();
      for (int i = 0; i < NREQ; i++) begin
         req_wdata[32*i +: 32] = 32'hA000_0000 + 32'(i);
         req_wstrb[4*i +: 4]   = 4'b1111;
         req_addr[32*i +: 32]  = 32'h0300_0100 + 32'(i);
      end
      req_wdata[95:64] = 32'h1234_5678;
      req_wstrb[11:8]  = 4'b0011;
      req_valid        = 4'b0100;
      step();
      total++;
      if (grant_id !== 2'd2 || iomem_wdata !== 32'h1234_5678 || iomem_wstrb !== 4'b0011 || iomem_addr !== 32'h0300_0102) begin
         bad++; $display("FAIL write_route: got grant=%0d wdata=%h wstrb=%b addr=%h want 2 12345678 0011 03000102",
                         grant_id, iomem_wdata, iomem_wstrb, iomem_addr);
      end
      iomem_ready = 1'b1;
      settle();
      total++;
      if (req_ready !== 4'b0100) begin
         bad++; $display("FAIL write_ready: got %b want 0100", req_ready);
      end
      step();
      iomem_ready = 1'b0;
      req_valid   = '0;
      req_wstrb   = '0;
   endtask

   task automatic test_timeout();
      int vcnt;
      req_addr[31:0] = 32'h0300_0200;
      req_valid      = 4'b0001;
      vcnt           = 0;
`ifdef IOMEM_ARB_TIMEOUT_EN
      for (int k = 0; k < 8; k++) begin
         step();
         if (iomem_valid === 1'b1 && req_ready === 4'b0000) vcnt++;
      end
      total++;
      if (vcnt !== 8) begin
         bad++; $display("FAIL tmo_valid_cycles: got %0d want 8", vcnt);
      end
      step();
      total++;
      if (iomem_valid !== 1'b0 || req_ready !== 4'b0001 || req_rdata !== 32'hFFFF_FFFF) begin
         bad++; $display("FAIL tmo_abort: got valid=%b ready=%b rdata=%h want 0 0001 ffffffff",
                         iomem_valid, req_ready, req_rdata);
      end
      step();
      req_valid = '0;
      settle();
      total++;
      if (timeout_err !== 1'b1) begin
         bad++; $display("FAIL tmo_err_set: got %b want 1", timeout_err);
      end
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      settle();
      total++;
      if (timeout_err !== 1'b0) begin
         bad++; $display("FAIL tmo_err_clr: got %b want 0", timeout_err);
      end
`else
      for (int k = 0; k < 20; k++) begin
         step();
         if (iomem_valid === 1'b1 && req_ready === 4'b0000 && timeout_err === 1'b0) vcnt++;
      end
      total++;
      if (vcnt !== 20) begin
         bad++; $display("FAIL notmo_wait: got %0d good cycles want 20", vcnt);
      end
      iomem_ready = 1'b1;
      iomem_rdata = 32'h0000_0077;
      settle();
      total++;
      if (req_ready !== 4'b0001 || req_rdata !== 32'h0000_0077) begin
         bad++; $display("FAIL notmo_complete: got ready=%b rdata=%h want 0001 00000077", req_ready, req_rdata);
      end
      step();
      iomem_ready = 1'b0;
      req_valid   = '0;
`endif
   endtask

   task automatic test_ready_coincide();
      req_valid = 4'b0001;
      for (int k = 0; k < 7; k++) step();
      step();
      iomem_ready = 1'b1;
      iomem_rdata = 32'h5A5A_1234;
      settle();
      total++;
      if (iomem_valid !== 1'b1 || req_ready !== 4'b0001 || req_rdata !== 32'h5A5A_1234) begin
         bad++; $display("FAIL coincide_complete: got valid=%b ready=%b rdata=%h want 1 0001 5a5a1234",
                         iomem_valid, req_ready, req_rdata);
      end
      step();
      iomem_ready = 1'b0;
      req_valid   = '0;
      settle();
      total++;
      if (iomem_valid !== 1'b0 || req_ready !== 4'b0000 || timeout_err !== 1'b0) begin
         bad++; $display("FAIL coincide_after: got valid=%b ready=%b err=%b want 0 0000 0",
                         iomem_valid, req_ready, timeout_err);
      end
   endtask

   task automatic test_reset_mid_busy();
      req_valid = 4'b0010;
      step();
      total++;
      if (iomem_valid !== 1'b1 || grant_id !== 2'd1) begin
         bad++; $display("FAIL rst_pre_busy: got valid=%b grant=%0d want 1 1", iomem_valid, grant_id);
      end
      resetn = 1'b0;
      step();
      iomem_ready = 1'b1;
      settle();
      total++;
      if (iomem_valid !== 1'b0 || req_ready !== 4'b0000 || grant_id !== 2'd0) begin
         bad++; $display("FAIL rst_mid_busy: got valid=%b ready=%b grant=%0d want 0 0000 0",
                         iomem_valid, req_ready, grant_id);
      end
      iomem_ready = 1'b0;
      resetn      = 1'b1;
      req_valid   = 4'b1011;
      step();
      total++;
      if (iomem_valid !== 1'b1 || grant_id !== 2'd0) begin
         bad++; $display("FAIL rst_first_grant: got valid=%b grant=%0d want 1 0", iomem_valid, grant_id);
      end
      iomem_ready = 1'b1;
      step();
      iomem_ready = 1'b0;
      req_valid   = '0;
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_fairness();
      test_write_routing();
      test_timeout();
      test_ready_coincide();
      test_reset_mid_busy();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/iomem_arbiter.md
# iomem_arbiter

Round-robin arbiter sharing the single PicoRV32 `iomem` peripheral bus (GPIO, and peripherals added later at 0x03xx_xxxx) between NREQ independent requesters, e.g. several SoC/hart memory ports or a debug loader. It sits between the requesters and the board-level peripheral decode logic. It serialises transactions, routes the response back to the granted requester, and optionally aborts transactions a peripheral never acknowledges.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- TIMEOUT_CYCLES, 255, cycles in BUSY without `iomem_ready` before abort (1..65535)
- ERR_RDATA, 32'hFFFF_FFFF, read data returned on abort

Ports:
- CLKOUT  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- req_valid  in  NREQ  per-requester valid; held until matching req_ready
- req_ready  out  NREQ  one-cycle completion pulse, at most one bit set
- req_wstrb  in  4*NREQ  byte strobes, requester i at [4i+3:4i]; 0 = read
- req_addr  in  32*NREQ  address, requester i at [32i+31:32i]
- req_wdata  in  32*NREQ  write data, same packing
- req_rdata  out  32  shared read data, valid only with req_ready
- iomem_valid  out  1  downstream valid
- iomem_ready  in  1  downstream ready (single-cycle pulse)
- iomem_wstrb  out  4  downstream strobes
- iomem_addr  out  32  downstream address
- iomem_wdata  out  32  downstream write data
- iomem_rdata  in  32  downstream read data
- grant_id  out  $clog2(NREQ)  current/last granted requester
- busy  out  1  high in BUSY
- timeout_err  out  1  sticky abort flag
- err_clr  in  1  clears timeout_err

## Operation
- States: IDLE, BUSY, ABORT (ABORT only with the macro).
- IDLE: if any req_valid set, pick the first set bit searching from (last_grant+1) mod NREQ upward with wrap-around. Register grant_id, go BUSY. Otherwise stay.
- BUSY: iomem_valid=1. iomem_wstrb/addr/wdata = slice of granted requester (combinational mux on registered grant_id). On iomem_ready: req_ready[grant_id]=1 and req_rdata=iomem_rdata in the same cycle, last_grant<=grant_id, go IDLE.
- ABORT: one cycle. iomem_valid=0, req_ready[grant_id]=1, req_rdata=ERR_RDATA, timeout_err<=1, last_grant<=grant_id, go IDLE.
- iomem_ready outside BUSY is ignored; no req_ready is generated.
- Requesters follow PicoRV32 native protocol: valid drops, or a new transaction is presented, on the cycle after ready. The arbiter does not re-check req_valid once in BUSY.
- err_clr clears timeout_err. If a set event and err_clr coincide, set wins.
- Reset values: state IDLE, iomem_valid 0, req_ready 0, req_rdata 0, grant_id 0, last_grant NREQ-1 (requester 0 has first priority), busy 0, timeout_err 0, timeout counter 0.
- resetn low mid-transaction drops iomem_valid next edge and emits no req_ready. The in-flight transaction is lost.

## Timing
- Request visible at edge t in IDLE -> iomem_valid high from cycle t+1.
- Completion is combinational from iomem_ready to req_ready (zero added latency).
- Minimum spacing between downstream transactions: one IDLE cycle.
- Back-to-back throughput with a peripheral answering one cycle after valid: one transaction per 3 cycles.
- Timeout counter: cleared on BUSY entry, increments each BUSY cycle without ready. When it equals TIMEOUT_CYCLES-1 without ready, the next state is ABORT. ABORT is entered after exactly TIMEOUT_CYCLES BUSY cycles.
- iomem_ready in the same cycle the counter expires: ready wins, normal completion.
- Fairness: a continuously requesting requester waits at most NREQ-1 transactions.

## Configuration
- IOMEM_ARB_TIMEOUT_EN defined: timeout counter, ABORT state and timeout_err logic present.
- Not defined: BUSY waits indefinitely for iomem_ready. timeout_err is tied 0, err_clr is ignored, TIMEOUT_CYCLES and ERR_RDATA are unused.

## Structure
- Shared package `picoramsoc_pkg`: state encoding typedef (IDLE/BUSY/ABORT), IOMEM_BASE 8'h03 region constant, default ERR_RDATA.
- One sub-module `rr_pick`: combinational round-robin priority picker (inputs req vector and last_grant, outputs any/index). Reusable for future bus arbiters.
- Width: last_grant and grant_id are $clog2(NREQ) bits. Wrap is computed modulo NREQ, not modulo 2^width, so non-power-of-two NREQ is legal.

## Test plan
- Single read: req0 reads 0x0300_0000, peripheral returns 0x0000_00A5 one cycle after valid -> iomem_valid at t+1, req_ready[0] pulse with req_rdata 0x0000_00A5, grant_id 0.
- Fairness: all 4 requesters hold valid continuously -> grant order 0,1,2,3,0. Each requester receives exactly one req_ready per 4 transactions.
- Write routing: req2 writes 0x1234_5678, wstrb 4'b0011, while req1 is idle -> iomem_wdata 0x1234_5678, iomem_wstrb 4'b0011, only req_ready[2] pulses.
- Timeout (macro on, TIMEOUT_CYCLES=8): peripheral never readies -> iomem_valid high exactly 8 cycles, then req_ready pulse with 0xFFFF_FFFF and timeout_err=1. err_clr clears it.
- Ready/expiry coincidence: iomem_ready in the 8th BUSY cycle -> normal completion with peripheral data, timeout_err stays 0.
- Reset mid-BUSY: resetn low for 1 cycle during BUSY -> iomem_valid 0, no req_ready, grant_id 0. The next request from req0 is granted first.
